entrada_botao_sincronizador: RTL and testbench

//   Input stage feeding the processor I/O block. Synchronises the raw push-button and switches,

---
 rtl/entrada_botao_sincronizador_pkg.sv | 16 +
 rtl/entrada_botao_sincronizador_debounce_botao.sv | 62 ++++++
 rtl/entrada_botao_sincronizador.sv | 123 ++++++++++++
 tb/tb_entrada_botao_sincronizador.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/entrada_botao_sincronizador_pkg.sv
// Purpose: shared definitions for the push-button/switch input stage.
//   estado_t   : latch FSM encoding (VAZIO = no pending value, CHEIO = value pending)
//   IO_SAIDA   : I/O control code for an output operation
//   IO_ENTRADA : I/O control code for an input read; the processor drives
//                leitura = (entradaSaidaControl == IO_ENTRADA)
package entrada_botao_sincronizador_pkg;

  typedef enum logic {
    VAZIO = 1'b0,
    CHEIO = 1'b1
  } estado_t;

  localparam logic [1:0] IO_SAIDA   = 2'b01;
  localparam logic [1:0] IO_ENTRADA = 2'b10;

endpackage

// File: rtl/entrada_botao_sincronizador_debounce_botao.sv
// Purpose: 2-flop synchroniser, polarity normalisation and debounce for the
//          raw push-button.
// Ports:
//   clk          in  system clock, posedge
//   reset        in  asynchronous, active-low
//   botaoIN      in  raw board push-button (asynchronous)
//   botao_limpo  out debounced button level, 1 = pressed (registered)
module debounce_botao #(
  parameter int unsigned DEBOUNCE_CICLOS   = 500000,
  parameter int unsigned BOTAO_ATIVO_BAIXO = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic botaoIN,
  output logic botao_limpo
);

  localparam int unsigned LARGURA_CONT = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
  localparam logic NIVEL_SOLTO = (BOTAO_ATIVO_BAIXO != 0);
  localparam logic [LARGURA_CONT-1:0] CONT_FIM = LARGURA_CONT'(DEBOUNCE_CICLOS - 1);

  logic                    r_sync1;
  logic                    r_sync2;
  logic [LARGURA_CONT-1:0] r_cont;
  logic                    r_limpo;
  logic                    w_pressionado;
  logic                    w_diferente;

  // Pressed = raw level opposite to the released level.
  assign w_pressionado = r_sync2 ^ NIVEL_SOLTO;
  assign w_diferente   = (w_pressionado != r_limpo);

  // Synchroniser resets to the released level so reset never looks like a press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= NIVEL_SOLTO;
      r_sync2 <= NIVEL_SOLTO;
    end else begin
      r_sync1 <= botaoIN;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a level change only after DEBOUNCE_CICLOS consecutive mismatch cycles;
  // the counter tops out at DEBOUNCE_CICLOS-1 and is cleared on toggle, so it never wraps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cont  <= '0;
      r_limpo <= 1'b0;
    end else if (!w_diferente) begin
      r_cont  <= '0;
    end else if (r_cont == CONT_FIM) begin
      r_cont  <= '0;
      r_limpo <= ~r_limpo;
    end else begin
      r_cont  <= r_cont + LARGURA_CONT'(1);
    end
  end

  assign botao_limpo = r_limpo;

endmodule

// File: rtl/entrada_botao_sincronizador.sv
// Purpose: input stage for the processor I/O block. Synchronises switches,
//          debounces the button and latches the switch value on each press,
//          holding it with a valid flag until an input read consumes it.
// Ports:
//   clk          in  system clock, posedge
//   reset        in  asynchronous, active-low
//   botaoIN      in  raw push-button (asynchronous)
//   chaves       in  raw switches (asynchronous), LARGURA_DADO bits
//   leitura      in  one-cycle consume pulse from processor input read
//   dado         out latched switch value
//   dado_valido  out dado holds an unconsumed value
//   sobrescrita  out sticky overrun flag, cleared only by reset
//   botao_limpo  out debounced button level, 1 = pressed
module entrada_botao_sincronizador
  import entrada_botao_sincronizador_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CICLOS   = 500000,
  parameter int unsigned LARGURA_DADO      = 4,
  parameter int unsigned BOTAO_ATIVO_BAIXO = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    botaoIN,
  input  logic [LARGURA_DADO-1:0] chaves,
  input  logic                    leitura,
  output logic [LARGURA_DADO-1:0] dado,
  output logic                    dado_valido,
  output logic                    sobrescrita,
  output logic                    botao_limpo
);

  logic [LARGURA_DADO-1:0] r_chaves_s1;
  logic [LARGURA_DADO-1:0] r_chaves_s2;
  logic                    w_botao_limpo;
  logic                    r_limpo_ant;
  logic                    r_pressao;
  estado_t                 r_estado;
  estado_t                 w_estado_prox;
  logic [LARGURA_DADO-1:0] r_dado;
  logic [LARGURA_DADO-1:0] w_dado_prox;
  logic                    r_sobrescrita;
  logic                    w_sobrescrita_prox;

  debounce_botao #(
    .DEBOUNCE_CICLOS  (DEBOUNCE_CICLOS),
    .BOTAO_ATIVO_BAIXO(BOTAO_ATIVO_BAIXO)
  ) u_debounce (
    .clk        (clk),
    .reset      (reset),
    .botaoIN    (botaoIN),
    .botao_limpo(w_botao_limpo)
  );

  // Per-bit 2-flop synchroniser for the switches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_chaves_s1 <= '0;
      r_chaves_s2 <= '0;
    end else begin
      r_chaves_s1 <= chaves;
      r_chaves_s2 <= r_chaves_s1;
    end
  end

  // One-cycle press pulse on the debounced rising edge; releases produce nothing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_limpo_ant <= 1'b0;
      r_pressao   <= 1'b0;
    end else begin
      r_limpo_ant <= w_botao_limpo;
      r_pressao   <= w_botao_limpo & ~r_limpo_ant;
    end
  end

  // Latch FSM state and its registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_estado      <= VAZIO;
      r_dado        <= '0;
      r_sobrescrita <= 1'b0;
    end else begin
      r_estado      <= w_estado_prox;
      r_dado        <= w_dado_prox;
      r_sobrescrita <= w_sobrescrita_prox;
    end
  end

  // Next state: a press always reloads; a simultaneous read consumes the old value,
  // so it is not counted as an overrun.
  always_comb begin
    w_estado_prox      = r_estado;
    w_dado_prox        = r_dado;
    w_sobrescrita_prox = r_sobrescrita;
    case (r_estado)
      VAZIO: begin
        if (r_pressao) begin
          w_dado_prox   = r_chaves_s2;
          w_estado_prox = CHEIO;
        end
      end
      CHEIO: begin
        if (r_pressao) begin
          w_dado_prox = r_chaves_s2;
          if (!leitura) begin
            w_sobrescrita_prox = 1'b1;
          end
        end else if (leitura) begin
          w_estado_prox = VAZIO;
        end
      end
      default: begin
        w_estado_prox = VAZIO;
      end
    endcase
  end

  assign dado        = r_dado;
  assign dado_valido = (r_estado == CHEIO);
  assign sobrescrita = r_sobrescrita;
  assign botao_limpo = w_botao_limpo;

endmodule

// File: tb/tb_entrada_botao_sincronizador.sv
module tb_entrada_botao_sincronizador;

  localparam int unsigned N = 4;
  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         botaoIN;
  logic [W-1:0] chaves;
  logic         leitura;
  logic [W-1:0] dado;
  logic         dado_valido;
  logic         sobrescrita;
  logic         botao_limpo;

  int total = 0;
  int bad   = 0;

  // Reference model: raw samples per edge since reset, plus abstract state.
  bit           q_press[$];
  logic [W-1:0] q_chaves[$];
  bit           m_limpo, m_limpo_ant, m_pressao, m_valid, m_sobre;
  logic [W-1:0] m_dado;

  always #5 clk = ~clk;

  entrada_botao_sincronizador #(
    .DEBOUNCE_CICLOS  (N),
    .LARGURA_DADO     (W),
    .BOTAO_ATIVO_BAIXO(1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .botaoIN    (botaoIN),
    .chaves     (chaves),
    .leitura    (leitura),
    .dado       (dado),
    .dado_valido(dado_valido),
    .sobrescrita(sobrescrita),
    .botao_limpo(botao_limpo)
  );

  function automatic bit press_at(int i);
    if (i < 0) return 1'b0;
    return q_press[i];
  endfunction

  function automatic logic [W-1:0] chaves_at(int i);
    if (i < 0) return '0;
    return q_chaves[i];
  endfunction

  task automatic model_clear();
    q_press.delete();
    q_chaves.delete();
    m_limpo = 0; m_limpo_ant = 0; m_pressao = 0; m_valid = 0; m_sobre = 0;
    m_dado = '0;
  endtask

  // One clock edge of the reference: the synchronised value after edge e is the raw
  // sample of edge e-1; the level flips once the last N synchronised values all differ.
  task automatic model_edge();
    int           e;
    bit           todos;
    bit           novo_pressao;
    logic [W-1:0] cs;
    q_press.push_back(!botaoIN);
    q_chaves.push_back(chaves);
    e = q_press.size() - 1;
    novo_pressao = m_limpo && !m_limpo_ant;
    cs = chaves_at(e - 2);
    if (!m_valid) begin
      if (m_pressao) begin m_dado = cs; m_valid = 1; end
    end else begin
      if (m_pressao) begin
        m_dado = cs;
        if (!leitura) m_sobre = 1;
      end else if (leitura) begin
        m_valid = 0;
      end
    end
    todos = 1;
    for (int j = 2; j <= int'(N) + 1; j++) if (press_at(e - j) == m_limpo) todos = 0;
    m_limpo_ant = m_limpo;
    if (todos) m_limpo = !m_limpo;
    m_pressao = novo_pressao;
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) model_edge();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; botaoIN = 1'($urandom); chaves = 4'($urandom); leitura = 1'($urandom);
    #2; model_clear();
    total++;
    if ({dado, dado_valido, sobrescrita, botao_limpo} !== 7'b0) begin
      bad++; $display("FAIL reset_async got=%b exp=%b", {dado, dado_valido, sobrescrita, botao_limpo}, 7'b0);
    end
    repeat (3) begin
      botaoIN = 1'($urandom); chaves = 4'($urandom); leitura = 1'($urandom);
      step();
      total++;
      if ({dado, dado_valido, sobrescrita, botao_limpo} !== 7'b0) begin
        bad++; $display("FAIL reset_held got=%b exp=%b", {dado, dado_valido, sobrescrita, botao_limpo}, 7'b0);
      end
    end
    botaoIN = 1'b1; chaves = '0; leitura = 1'b0; reset = 1'b1;
    repeat (6) begin
      step();
      total++;
      if ({dado, dado_valido, sobrescrita, botao_limpo} !== 7'b0) begin
        bad++; $display("FAIL reset_release got=%b exp=%b", {dado, dado_valido, sobrescrita, botao_limpo}, 7'b0);
      end
    end
  endtask

  task automatic test_press();
    chaves = 4'hA; botaoIN = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step();
      total++;
      if ({dado, dado_valido, sobrescrita, botao_limpo} !== {m_dado, m_valid, m_sobre, m_limpo}) begin
        bad++; $display("FAIL press_model i=%0d got=%b exp=%b", i, {dado, dado_valido, sobrescrita, botao_limpo}, {m_dado, m_valid, m_sobre, m_limpo});
      end
      if (i == 5 || i == 6) begin
        total++;
        if (botao_limpo !== (i == 6)) begin
          bad++; $display("FAIL press_limpo_latency i=%0d got=%b exp=%b", i, botao_limpo, (i == 6));
        end
      end
      if (i == 7 || i == 8) begin
        total++;
        if ({dado_valido, dado} !== ((i == 8) ? 5'h1A : 5'h00)) begin
          bad++; $display("FAIL press_valid_latency i=%0d got=%h exp=%h", i, {dado_valido, dado}, ((i == 8) ? 5'h1A : 5'h00));
        end
      end
    end
    leitura = 1'b1; step(); leitura = 1'b0;
    total++;
    if ({dado_valido, dado} !== 5'h0A) begin
      bad++; $display("FAIL press_consume got=%h exp=%h", {dado_valido, dado}, 5'h0A);
    end
    botaoIN = 1'b1;
    repeat (8) begin
      step();
      total++;
      if ({dado, dado_valido, sobrescrita, botao_limpo} !== {m_dado, m_valid, m_sobre, m_limpo}) begin
        bad++; $display("FAIL press_release got=%b exp=%b", {dado, dado_valido, sobrescrita, botao_limpo}, {m_dado, m_valid, m_sobre, m_limpo});
      end
    end
  endtask

  task automatic test_bounce();
    logic [W-1:0] v;
    repeat (4) begin
      for (int i = 0; i < 4; i++) begin
        botaoIN = (i == 3);
        step();
        total++;
        if ({botao_limpo, dado_valido} !== 2'b00 ||
            {dado, dado_valido, sobrescrita, botao_limpo} !== {m_dado, m_valid, m_sobre, m_limpo}) begin
          bad++; $display("FAIL bounce got=%b exp=%b", {dado, dado_valido, sobrescrita, botao_limpo}, {m_dado, m_valid, m_sobre, m_limpo});
        end
      end
    end
    v = 4'($urandom); chaves = v; botaoIN = 1'b0;
    repeat (9) step();
    total++;
    if ({dado_valido, dado} !== {1'b1, v}) begin
      bad++; $display("FAIL bounce_then_hold got=%h exp=%h", {dado_valido, dado}, {1'b1, v});
    end
    leitura = 1'b1; step(); leitura = 1'b0;
    botaoIN = 1'b1;
    repeat (8) step();
    total++;
    if ({dado, dado_valido, sobrescrita, botao_limpo} !== {m_dado, m_valid, m_sobre, m_limpo}) begin
      bad++; $display("FAIL bounce_release got=%b exp=%b", {dado, dado_valido, sobrescrita, botao_limpo}, {m_dado, m_valid, m_sobre, m_limpo});
    end
  endtask

  task automatic test_overwrite();
    chaves = 4'h3; botaoIN = 1'b0; repeat (8) step();
    botaoIN = 1'b1; repeat (8) step();
    chaves = 4'h5; botaoIN = 1'b0; repeat (8) step();
    total++;
    if ({dado, dado_valido, sobrescrita} !== {4'h5, 1'b1, 1'b1}) begin
      bad++; $display("FAIL overwrite got=%b exp=%b", {dado, dado_valido, sobrescrita}, {4'h5, 1'b1, 1'b1});
    end
    leitura = 1'b1; step(); leitura = 1'b0;
    total++;
    if ({dado_valido, sobrescrita} !== 2'b01 ||
        {dado, dado_valido, sobrescrita, botao_limpo} !== {m_dado, m_valid, m_sobre, m_limpo}) begin
      bad++; $display("FAIL overwrite_sticky got=%b exp=%b", {dado, dado_valido, sobrescrita, botao_limpo}, {m_dado, m_valid, m_sobre, m_limpo});
    end
    botaoIN = 1'b1; repeat (8) step();
  endtask

  task automatic test_simultaneous();
    bit achou;
    reset = 1'b0; #2; model_clear(); reset = 1'b1;
    chaves = 4'h3; botaoIN = 1'b0; repeat (8) step();
    botaoIN = 1'b1; repeat (8) step();
    total++;
    if ({dado, dado_valido, sobrescrita} !== {4'h3, 1'b1, 1'b0}) begin
      bad++; $display("FAIL simult_setup got=%b exp=%b", {dado, dado_valido, sobrescrita}, {4'h3, 1'b1, 1'b0});
    end
    chaves = 4'h7; botaoIN = 1'b0;
    achou = 0;
    for (int i = 0; i < 20 && !achou; i++) begin
      step();
      if (m_pressao) achou = 1;
    end
    total++;
    if (!achou) begin
      bad++; $display("FAIL simult_timeout got=no_press exp=press");
    end
    leitura = 1'b1; step(); leitura = 1'b0;
    total++;
    if ({dado, dado_valido, sobrescrita} !== {4'h7, 1'b1, 1'b0}) begin
      bad++; $display("FAIL simult_read_press got=%b exp=%b", {dado, dado_valido, sobrescrita}, {4'h7, 1'b1, 1'b0});
    end
    botaoIN = 1'b1; repeat (8) step();
    leitura = 1'b1; step(); leitura = 1'b0;
  endtask

  task automatic test_reset_mid();
    chaves = 4'h9; botaoIN = 1'b0;
    repeat (4) step();
    reset = 1'b0; #1; model_clear();
    total++;
    if ({dado, dado_valido, sobrescrita, botao_limpo} !== 7'b0) begin
      bad++; $display("FAIL reset_mid got=%b exp=%b", {dado, dado_valido, sobrescrita, botao_limpo}, 7'b0);
    end
    #2; reset = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      step();
      total++;
      if (dado_valido !== (i >= 8) ||
          {dado, dado_valido, sobrescrita, botao_limpo} !== {m_dado, m_valid, m_sobre, m_limpo}) begin
        bad++; $display("FAIL reset_mid_relatch i=%0d got=%b exp=%b", i, {dado, dado_valido, sobrescrita, botao_limpo}, {m_dado, m_valid, m_sobre, m_limpo});
      end
    end
    botaoIN = 1'b1; repeat (8) step();
  endtask

  task automatic test_random();
    int run;
    run = 0;
    for (int i = 0; i < 1500; i++) begin
      if (run == 0) begin
        botaoIN = ~botaoIN;
        run = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 12);
      end
      run--;
      if ($urandom_range(0, 3) == 0) chaves = 4'($urandom);
      leitura = ($urandom_range(0, 5) == 0);
      step();
      total++;
      if ({dado, dado_valido, sobrescrita, botao_limpo} !== {m_dado, m_valid, m_sobre, m_limpo}) begin
        bad++; $display("FAIL random i=%0d got=%b exp=%b", i, {dado, dado_valido, sobrescrita, botao_limpo}, {m_dado, m_valid, m_sobre, m_limpo});
      end
    end
    leitura = 1'b0;
  endtask

  initial begin
    reset = 1'b0; botaoIN = 1'b1; chaves = '0; leitura = 1'b0;
    model_clear();
    test_reset();
    test_press();
    test_bounce();
    test_overwrite();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
